vga_sync_gen: RTL

Display timing generator that drives the scan position into the game-object renderer and turns its colour output into the signals on the VGA pins. It produces `col_counter`/`row_counter` for the renderer and takes back 8-bit RGB332 `rgb` on `rgb_in`. It delays sync and blanking by the renderer's latency and registers `hsync`, `vsync` and blanked `rgb_out` together, so all three reach the pins aligned. Default timing is 800x600@72 Hz from a 50 MHz pixel clock.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_sync_gen_if.sv | 36 +++
 rtl/sync_delay_line.sv | 34 +++
 rtl/vga_sync_gen.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, scan-counter type and colour-bar palette for the VGA sync generator.
package vga_pkg;

  localparam int DEF_DISP_COLS = 800;
  localparam int DEF_DISP_ROWS = 600;
  localparam int DEF_H_FP      = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BP      = 64;
  localparam int DEF_V_FP      = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 23;

  localparam int CNT_W     = 12;
  localparam int MAX_TOTAL = 4096;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic visible;
    logic hs_act;
    logic vs_act;
  } sync_flags_t;

  localparam logic [7:0] BAR_COLORS [0:7] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C,
                                              8'hE3, 8'hE0, 8'h03, 8'h00};

  // Half-open window test done in int so an upper bound of 4096 still works.
  function automatic logic in_range(input cnt_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the sync generator (master) and the renderer/pin side (slave).
// The test_pattern signal exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_sync_gen_if;
  import vga_pkg::*;

  cnt_t       col_counter;
  cnt_t       row_counter;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [7:0] rgb_in;
  logic [7:0] rgb_out;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_pattern;
`endif

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  test_pattern,
`endif
    input  rgb_in,
    output col_counter, row_counter, frame_start,
    output hsync, vsync, video_on, rgb_out
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output test_pattern,
`endif
    output rgb_in,
    input  col_counter, row_counter, frame_start,
    input  hsync, vsync, video_on, rgb_out
  );

endinterface

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous reset value; DEPTH 0 is a plain wire.
module sync_delay_line #(
  parameter int              WIDTH       = 3,
  parameter int              DEPTH       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: scan counters, latency-matched sync/blank flags and registered pin outputs.
// Build macro VGA_TEST_PATTERN_EN adds a colour-bar override selected by test_pattern.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   DISP_COLS   = DEF_DISP_COLS,
  parameter int   DISP_ROWS   = DEF_DISP_ROWS,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   RGB_LATENCY = 0
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master vga
);

  localparam int   H_TOTAL  = DISP_COLS + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = DISP_ROWS + V_FP + V_SYNC + V_BP;
  localparam int   HS_START = DISP_COLS + H_FP;
  localparam int   HS_END   = HS_START + H_SYNC;
  localparam int   VS_START = DISP_ROWS + V_FP;
  localparam int   VS_END   = VS_START + V_SYNC;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
`ifdef VGA_TEST_PATTERN_EN
  localparam int   BAR_W    = DISP_COLS / 8;
  localparam int   FLAG_W   = 6;
`else
  localparam int   FLAG_W   = 3;
`endif

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (RGB_LATENCY < 0 || RGB_LATENCY > 7) begin : g_latency_check
      $error("vga_sync_gen: RGB_LATENCY must be in 0..7");
    end
  endgenerate

  cnt_t        col, row, col_next, row_next;
  logic        frame_start_q;
  logic        hsync_q, vsync_q, video_on_q;
  logic [7:0]  rgb_q, pixel;
  sync_flags_t flags_now, flags_dly;
  logic [FLAG_W-1:0] line_in, line_out;

  always_comb begin
    col_next = col + cnt_t'(1);
    row_next = row;
    if (col == H_LAST) begin
      col_next = '0;
      row_next = (row == V_LAST) ? '0 : row + cnt_t'(1);
    end
  end

  // frame_start is decoded from the next counter values so it lines up with the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      col           <= col_next;
      row           <= row_next;
      frame_start_q <= (col_next == '0) && (row_next == cnt_t'(DISP_ROWS));
    end
  end

  always_comb begin
    flags_now.visible = (int'(col) < DISP_COLS) && (int'(row) < DISP_ROWS);
    flags_now.hs_act  = in_range(col, HS_START, HS_END);
    flags_now.vs_act  = in_range(row, VS_START, VS_END);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_now, bar_dly;

  // Bar index counts how many bar boundaries the column has passed, avoiding a divider.
  always_comb begin
    bar_now = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(col) >= k * BAR_W) bar_now = bar_now + 3'd1;
    end
  end

  assign line_in              = {flags_now, bar_now};
  assign {flags_dly, bar_dly} = line_out;
  assign pixel = vga.test_pattern ? BAR_COLORS[bar_dly] : vga.rgb_in;
`else
  assign line_in   = flags_now;
  assign flags_dly = line_out;
  assign pixel     = vga.rgb_in;
`endif

  sync_delay_line #(
    .WIDTH (FLAG_W),
    .DEPTH (RGB_LATENCY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (line_in),
    .dout (line_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b0;
      rgb_q      <= 8'h00;
    end else begin
      hsync_q    <= flags_dly.hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= flags_dly.vs_act ? SYNC_POL : ~SYNC_POL;
      video_on_q <= flags_dly.visible;
      rgb_q      <= flags_dly.visible ? pixel : 8'h00;
    end
  end

  assign vga.col_counter = col;
  assign vga.row_counter = row;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.rgb_out     = rgb_q;

endmodule
